// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter for the single regfile write port. NUM_REQ
//            writeback sources each offer one write through valid/ready; at
//            most one is granted per cycle and registered onto the regfile
//            write port.
// Ports    : clk, rst_n              clock, asynchronous active-low reset
//            req_valid/addr/data     per-requester write offer (packed)
//            req_ready               one-hot grant, combinational
//            stall                   suppress all grants this cycle
//            write_enable/addr/data  registered regfile write port
//            grant_id                index of last accepted requester
//            wr_count                saturating count of write_enable pulses
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ZERO_DISCARD = 1,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_addr,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    stall,
    output logic                    write_enable,
    output logic [4:0]              write_addr,
    output logic [31:0]             write_data,
    output logic [2:0]              grant_id,
    output logic [CNT_W-1:0]        wr_count
);

    localparam logic [3:0] c_num_req  = 4'(NUM_REQ);
    localparam logic [2:0] c_ptr_init = 3'(NUM_REQ - 1);

    logic [2:0]              r_ptr;
    logic [2*NUM_REQ-1:0]    w_dbl;
    logic [2*NUM_REQ-1:0]    w_rot;
    logic [3:0]              w_off;
    logic [3:0]              w_sum;
    logic [2:0]              w_sel;
    logic                    w_found;
    logic [5*NUM_REQ-1:0]    w_addr_sh;
    logic [32*NUM_REQ-1:0]   w_data_sh;
    logic [4:0]              w_addr;
    logic [31:0]             w_data;
    logic                    w_we_next;

    // Rotate the valid vector so that bit 0 is the requester right after the
    // pointer; the lowest set bit of the rotated vector is then the winner.
    always_comb begin
        w_dbl   = {req_valid, req_valid};
        w_rot   = w_dbl >> ({1'b0, r_ptr} + 4'd1);
        w_found = 1'b0;
        w_off   = 4'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = 4'(k);
            end
        end
        // ptr + 1 + off is at most 2*NUM_REQ-1, so one subtraction wraps it
        w_sum = {1'b0, r_ptr} + 4'd1 + w_off;
        if (w_sum >= c_num_req) begin
            w_sum = w_sum - c_num_req;
        end
        w_sel = w_sum[2:0];
        if (stall) begin
            w_found = 1'b0;
        end
        req_ready = w_found ? (NUM_REQ'(1) << w_sel) : '0;
    end

    // Select the winner's address/data by shifting its slice down to bit 0
    always_comb begin
        w_addr_sh = req_addr >> (5 * w_sel);
        w_data_sh = req_data >> (32 * w_sel);
        w_addr    = w_addr_sh[4:0];
        w_data    = w_data_sh[31:0];
        // Writes to r0 still complete the handshake but never reach the regfile
        w_we_next = w_found && !((ZERO_DISCARD != 0) && (w_addr == 5'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= c_ptr_init;
            write_enable <= 1'b0;
            write_addr   <= 5'd0;
            write_data   <= 32'd0;
            grant_id     <= 3'd0;
            wr_count     <= '0;
        end else begin
            write_enable <= w_we_next;
            if (w_found) begin
                r_ptr      <= w_sel;
                grant_id   <= w_sel;
                write_addr <= w_addr;
                write_data <= w_data;
            end
            // Counts each cycle the write port was driven, stopping at all-ones
            if (write_enable && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter (NUM_REQ=3,
//            ZERO_DISCARD=1, CNT_W=4 so saturation is reachable).
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [5*NUM_REQ-1:0]  req_addr;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  stall;
    logic                  write_enable;
    logic [4:0]            write_addr;
    logic [31:0]           write_data;
    logic [2:0]            grant_id;
    logic [CNT_W-1:0]      wr_count;

    regfile_wb_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ZERO_DISCARD (1),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .stall        (stall),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .grant_id     (grant_id),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shadow regfile fed by the DUT write port
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (write_enable) rf[write_addr] <= write_data;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [2:0]  gid;
    } exp_t;

    exp_t        sbq[$];
    int          m_ptr;
    int          m_cnt;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [2:0]  m_gid;
    int          last_grant;

    task automatic model_reset();
        m_ptr  = NUM_REQ - 1;
        m_cnt  = 0;
        m_addr = '0;
        m_data = '0;
        m_gid  = '0;
        sbq.delete();
    endtask

    function automatic int model_grant();
        if (stall) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]        = v;
        req_addr[i*5 +: 5]  = a;
        req_data[i*32 +: 32] = d;
    endtask

    // One clock cycle: inputs are already driven (we are just after negedge).
    task automatic step();
        int   g;
        exp_t e;
        logic [NUM_REQ-1:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = (g < 0) ? '0 : NUM_REQ'(1 << g);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        e.we = 1'b0;
        if (g >= 0) begin
            m_ptr  = g;
            m_gid  = 3'(g);
            m_addr = req_addr[g*5 +: 5];
            m_data = req_data[g*32 +: 32];
            e.we   = (m_addr != 5'd0);
        end
        e.addr = m_addr;
        e.data = m_data;
        e.gid  = m_gid;
        sbq.push_back(e);
        last_grant = g;
        @(negedge clk);
        check("wr_count", 64'(wr_count), 64'(m_cnt));
        e = sbq.pop_front();
        check("write_enable", 64'(write_enable), 64'(e.we));
        check("write_addr", 64'(write_addr), 64'(e.addr));
        check("write_data", 64'(write_data), 64'(e.data));
        check("grant_id", 64'(grant_id), 64'(e.gid));
        if (e.we && m_cnt < CNT_MAX) m_cnt++;
    endtask

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_we", 64'(write_enable), 64'd0);
        check("rst_addr", 64'(write_addr), 64'd0);
        check("rst_data", 64'(write_data), 64'd0);
        check("rst_gid", 64'(grant_id), 64'd0);
        check("rst_cnt", 64'(wr_count), 64'd0);
        rst_n = 1'b1;

        // Single write from requester 0
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        set_req(0, 1'b0, 5'd0, 32'h0);
        step();
        step();

        // Same-address pair after a grant to requester 0
        set_req(0, 1'b1, 5'd3, 32'h3333);
        step();
        set_req(0, 1'b1, 5'd7, 32'h11);
        set_req(1, 1'b1, 5'd7, 32'h22);
        step();
        set_req(1, 1'b0, 5'd0, 32'h0);
        step();
        set_req(0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        check("rf_r7", 64'(rf[7]), 64'h11);

        // Zero-address write is accepted but discarded
        set_req(1, 1'b1, 5'd0, 32'h55);
        step();
        set_req(1, 1'b0, 5'd0, 32'h0);
        step();

        // Stall for three cycles, then grant
        stall = 1'b1;
        set_req(0, 1'b1, 5'd9, 32'hA5A5);
        repeat (3) step();
        stall = 1'b0;
        step();
        set_req(0, 1'b0, 5'd0, 32'h0);
        step();

        // Reset asserted right after an accept: the write is lost
        set_req(2, 1'b1, 5'd12, 32'hCAFE);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_we", 64'(write_enable), 64'd0);
        check("async_cnt", 64'(wr_count), 64'd0);
        check("async_addr", 64'(write_addr), 64'd0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters continuously valid: 0,1,2,0,1,2
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'(i * 16 + 1));
        for (int c = 0; c < 6; c++) begin
            step();
            check("rr_order", 64'(grant_id), 64'(c % NUM_REQ));
            if (last_grant >= 0)
                set_req(last_grant, 1'b1, 5'($urandom_range(1, 31)), $urandom);
        end
        req_valid = '0;
        step();

        // Random traffic with stalls, drops and zero addresses; saturates wr_count
        for (int c = 0; c < 200; c++) begin
            stall = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        end
        stall     = 1'b0;
        req_valid = '0;
        step();
        check("cnt_saturated", 64'(wr_count), 64'(CNT_MAX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
